rom_fifo_sched: RTL and testbench

- Write-side scheduler between the display pattern ROM and the 100 MHz write port of the cross-clock pixel FIFO.
- Generates ROM read addresses for one frame, absorbs the ROM read latency in an internal skid buffer, and pushes pixels into the FIFO under fifo_full backpressure without loss or duplication.
- Signals frame completion, and optionally restarts automatically for continuous display.

---
 rtl/rom_fifo_sched_if.sv | 46 ++++
 rtl/rom_fifo_sched.sv | 170 +++++++++++++++++
 tb/tb_rom_fifo_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_fifo_sched_if.sv
// Bus bundle for the frame scheduler that sits between the pattern ROM and
// the write port of the pixel FIFO. Also carries the control/status strobes
// and two debug taps (FSM state, skid occupancy).
//
// Handshake semantics:
//   ROM side  - rom_en is a read request. The ROM has no stall, so rom_data
//               for that address is valid exactly ROM_LAT cycles later.
//   FIFO side - fifo_full acts as the inverted ready. A pixel is transferred
//               in every cycle where fifo_wr_en=1. fifo_wr_en is never raised
//               while fifo_full=1. fifo_din is meaningful only when
//               fifo_wr_en=1.
interface rom_fifo_sched_if #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 19,
  parameter int SKID_DEPTH = 4
);
  localparam int SCW = $clog2(SKID_DEPTH + 1);

  logic              start;
  logic              continuous;
  logic              abort;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_din;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;
  logic [SCW-1:0]    skid_cnt_dbg;

  // Scheduler side
  modport master (
    input  start, continuous, abort, rom_data, fifo_full,
    output rom_en, rom_addr, fifo_wr_en, fifo_din, busy, done,
           state_dbg, skid_cnt_dbg
  );

  // Environment side (controller, ROM, FIFO)
  modport slave (
    output start, continuous, abort, rom_data, fifo_full,
    input  rom_en, rom_addr, fifo_wr_en, fifo_din, busy, done,
           state_dbg, skid_cnt_dbg
  );
endinterface

// File: rtl/rom_fifo_sched.sv
// Write-side frame scheduler. It issues ROM reads for one frame and tracks
// the reads still in flight in a ROM_LAT-deep valid shift register. Returning
// data is caught in a small skid buffer, and the buffer is drained into the
// pixel FIFO under fifo_full backpressure.
// A read is issued only while skid occupancy plus reads in flight is below
// SKID_DEPTH. Every returning pixel therefore has a free slot, so no pixel is
// lost.
module rom_fifo_sched #(
  parameter int DATA_W       = 24,
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200,
  parameter int ROM_LAT      = 2,
  parameter int SKID_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_fifo_sched_if.master     bus
);

  // One extra bit so that a count can reach FRAME_PIXELS = 2**ADDR_W
  localparam int CNT_W = ADDR_W + 1;
  localparam int SCW   = $clog2(SKID_DEPTH + 1);
  localparam int PW    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ROM_LAT-1:0] vld_q, vld_d;
  logic [ROM_LAT:0]  vld_ext;
  logic [DATA_W-1:0] skid_mem_q [SKID_DEPTH];
  logic [DATA_W-1:0] skid_mem_d [SKID_DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [SCW-1:0]    skid_cnt_q, skid_cnt_d;

  logic [SCW-1:0]    inflight;
  logic [CNT_W-1:0]  issue_cnt_adv;
  logic [CNT_W-1:0]  wr_cnt_adv;
  logic              busy_states;
  logic              issue;
  logic              push;
  logic              pop;
  logic              clear;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Count the ROM reads whose data has not yet returned
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + SCW'(vld_q[i]);
    end
  end

  // Issue, capture and write strobes, all from registered state and fifo_full
  always_comb begin
    busy_states   = (state_q == S_FILL) || (state_q == S_DRAIN);
    issue         = (state_q == S_FILL) && (issue_cnt_q < FRAME_CNT) &&
                    (({1'b0, skid_cnt_q} + {1'b0, inflight}) < (SCW+1)'(SKID_DEPTH));
    push          = vld_q[ROM_LAT-1];
    pop           = busy_states && (skid_cnt_q != '0) && !bus.fifo_full;
    issue_cnt_adv = issue_cnt_q + CNT_W'(issue);
    wr_cnt_adv    = wr_cnt_q + CNT_W'(pop);
  end

  // Frame FSM: next state, plus the clear that starts every frame from zero
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_FILL;
            clear   = 1'b1;
          end
        end
        S_FILL: begin
          if (issue_cnt_adv == FRAME_CNT) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (wr_cnt_adv == FRAME_CNT) state_d = S_DONE;
        end
        S_DONE: begin
          clear   = 1'b1;
          state_d = bus.continuous ? S_FILL : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      endcase
    end
  end

  // Datapath next state: the in-flight shift, the skid ring and the counters
  always_comb begin
    vld_ext     = {vld_q, issue};
    vld_d       = vld_ext[ROM_LAT-1:0];
    skid_mem_d  = skid_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    skid_cnt_d  = skid_cnt_q + SCW'(push) - SCW'(pop);
    issue_cnt_d = issue_cnt_adv;
    wr_cnt_d    = wr_cnt_adv;
    if (push) begin
      skid_mem_d[tail_q] = bus.rom_data;
      tail_d             = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    // A clear drops reads still in flight, so late ROM data is never captured
    if (clear) begin
      vld_d       = '0;
      head_d      = '0;
      tail_d      = '0;
      skid_cnt_d  = '0;
      issue_cnt_d = '0;
      wr_cnt_d    = '0;
    end
  end

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      vld_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      skid_cnt_q  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      vld_q       <= vld_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      skid_cnt_q  <= skid_cnt_d;
      for (int i = 0; i < SKID_DEPTH; i++) skid_mem_q[i] <= skid_mem_d[i];
    end
  end

  // rom_addr follows the issue count, so it holds whenever nothing is issued
  assign bus.rom_en       = issue;
  assign bus.rom_addr     = issue_cnt_q[ADDR_W-1:0];
  assign bus.fifo_wr_en   = pop;
  assign bus.fifo_din     = skid_mem_q[head_q];
  assign bus.busy         = busy_states;
  assign bus.done         = (state_q == S_DONE);
  assign bus.state_dbg    = state_q;
  assign bus.skid_cnt_dbg = skid_cnt_q;

endmodule

// File: tb/tb_rom_fifo_sched.sv
// Bench for rom_fifo_sched with a 16-pixel frame. The ROM model returns the
// address as data after two cycles. The expected ROM addresses and FIFO
// pixels are queued when a frame is started. A negedge monitor pops a queue
// entry on every rom_en and on every fifo_wr_en, and compares it with what
// the DUT presents.
module tb_rom_fifo_sched;

  localparam int DATA_W     = 24;
  localparam int ADDR_W     = 19;
  localparam int FP         = 16;
  localparam int ROM_LAT    = 2;
  localparam int SKID_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rom_fifo_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SKID_DEPTH(SKID_DEPTH)) bus ();

  rom_fifo_sched #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_PIXELS(FP),
    .ROM_LAT(ROM_LAT), .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- ROM model: data = address, ROM_LAT cycles later ----------------
  logic [ADDR_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_en ? bus.rom_addr : '1;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_data = DATA_W'(rom_pipe[ROM_LAT-1]);

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic [DATA_W-1:0] exp_pix;
  logic [ADDR_W-1:0] exp_addr;
  int cyc = 0;
  int rom_seen, wr_seen, done_seen, skid_peak;
  int first_en, last_en, first_wr, last_wr, done_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (bus.rom_en === 1'b1) begin
      if (addr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rom_issue: unexpected rom_en with addr=%0d, none expected", bus.rom_addr);
      end else begin
        exp_addr = addr_q.pop_front();
        chk("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
      end
      if (rom_seen == 0) first_en = cyc;
      last_en = cyc;
      rom_seen++;
    end
    if (bus.fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL fifo_write: unexpected write din=%0d, none expected", bus.fifo_din);
      end else begin
        exp_pix = exp_q.pop_front();
        chk("fifo_din", 32'(bus.fifo_din), 32'(exp_pix));
      end
      if (wr_seen == 0) first_wr = cyc;
      last_wr = cyc;
      wr_seen++;
    end
    if (bus.done === 1'b1) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (32'(bus.skid_cnt_dbg) > skid_peak) skid_peak = 32'(bus.skid_cnt_dbg);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    rom_seen = 0; wr_seen = 0; done_seen = 0; skid_peak = 0;
    first_en = 0; last_en = 0; first_wr = 0; last_wr = 0; done_cyc = 0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < FP; i++) begin
      addr_q.push_back(ADDR_W'(i));
      exp_q.push_back(DATA_W'(i));
    end
  endtask

  task automatic flush_exp();
    addr_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_rom_en"},     32'(bus.rom_en),     32'd0);
    chk({tag, "_rom_addr"},   32'(bus.rom_addr),   32'd0);
    chk({tag, "_fifo_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
    chk({tag, "_fifo_din"},   32'(bus.fifo_din),   32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_done"},       32'(bus.done),       32'd0);
    chk({tag, "_state"},      32'(bus.state_dbg),  32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.abort      = 1'b0;
    bus.fifo_full  = 1'b0;
    clear_stats();

    // Reset values
    #12;
    chk_idle_zero("reset");
    tick();
    rst = 1'b1;
    tick();
    chk_idle_zero("post_reset");

    // Basic frame with no backpressure
    clear_stats();
    push_frame();
    pulse_start();
    wait_done("t1_done", 60);
    tick();
    chk("t1_rom_count",    32'(rom_seen), 32'd16);
    chk("t1_rom_contig",   32'(last_en - first_en), 32'd15);
    chk("t1_first_lat",    32'(first_wr - first_en), 32'd3);
    chk("t1_wr_count",     32'(wr_seen), 32'd16);
    chk("t1_wr_contig",    32'(last_wr - first_wr), 32'd15);
    chk("t1_done_lat",     32'(done_cyc - last_wr), 32'd1);
    chk("t1_done_count",   32'(done_seen), 32'd1);
    chk("t1_exp_empty",    32'(exp_q.size()), 32'd0);
    chk("t1_state_idle",   32'(bus.state_dbg), 32'd0);
    chk("t1_busy",         32'(bus.busy), 32'd0);

    // fifo_full in cycles 5..12 after the start cycle
    clear_stats();
    push_frame();
    tick();
    bus.start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      bus.start     = 1'b0;
      bus.fifo_full = (c >= 5 && c <= 12);
    end
    wait_done("t2_done", 80);
    repeat (5) tick();
    chk("t2_skid_peak",  32'(skid_peak), 32'd4);
    chk("t2_wr_count",   32'(wr_seen), 32'd16);
    chk("t2_done_count", 32'(done_seen), 32'd1);
    chk("t2_exp_empty",  32'(exp_q.size()), 32'd0);

    // Continuous mode: two back-to-back frames
    clear_stats();
    bus.continuous = 1'b1;
    push_frame();
    push_frame();
    pulse_start();
    wait_done("t3_done1", 60);
    @(negedge clk);
    chk("t3_restart_en",   32'(bus.rom_en), 32'd1);
    chk("t3_restart_addr", 32'(bus.rom_addr), 32'd0);
    tick();
    bus.continuous = 1'b0;
    wait_done("t3_done2", 60);
    tick();
    chk("t3_wr_count",   32'(wr_seen), 32'd32);
    chk("t3_done_count", 32'(done_seen), 32'd2);
    chk("t3_exp_empty",  32'(exp_q.size()), 32'd0);
    chk("t3_state_idle", 32'(bus.state_dbg), 32'd0);

    // Abort at issue count 7 with fifo_full raised
    clear_stats();
    push_frame();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (rom_seen >= 7) break;
      tick();
    end
    chk("t4_reach_issue7", 32'(rom_seen), 32'd7);
    bus.fifo_full = 1'b1;
    bus.abort     = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t4_state_idle", 32'(bus.state_dbg), 32'd0);
    chk("t4_rom_en",     32'(bus.rom_en), 32'd0);
    chk("t4_wr_en",      32'(bus.fifo_wr_en), 32'd0);
    chk("t4_busy",       32'(bus.busy), 32'd0);
    flush_exp();
    bus.fifo_full = 1'b0;
    repeat (10) tick();
    chk("t4_no_done",    32'(done_seen), 32'd0);
    clear_stats();
    push_frame();
    pulse_start();
    wait_done("t4_restart_done", 60);
    tick();
    chk("t4_restart_wr",  32'(wr_seen), 32'd16);
    chk("t4_restart_exp", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset at write count 9
    clear_stats();
    push_frame();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (wr_seen >= 9) break;
      tick();
    end
    chk("t5_reach_wr9", 32'(wr_seen), 32'd9);
    #2;
    rst = 1'b0;
    #1;
    chk_idle_zero("t5_async");
    flush_exp();
    tick();
    tick();
    rst = 1'b1;
    clear_stats();
    push_frame();
    pulse_start();
    wait_done("t5_restart_done", 60);
    tick();
    chk("t5_restart_wr",  32'(wr_seen), 32'd16);
    chk("t5_restart_exp", 32'(exp_q.size()), 32'd0);

    // start held high across FILL: no restart mid-frame
    clear_stats();
    push_frame();
    tick();
    bus.start = 1'b1;
    repeat (10) tick();
    bus.start = 1'b0;
    wait_done("t6_done", 60);
    tick();
    chk("t6_rom_count",  32'(rom_seen), 32'd16);
    chk("t6_wr_count",   32'(wr_seen), 32'd16);
    chk("t6_done_count", 32'(done_seen), 32'd1);
    chk("t6_exp_empty",  32'(exp_q.size()), 32'd0);

    // start and abort together during FILL: abort wins
    clear_stats();
    push_frame();
    pulse_start();
    tick();
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("t6_fill_abort_state", 32'(bus.state_dbg), 32'd0);
    chk("t6_fill_abort_busy",  32'(bus.busy), 32'd0);
    flush_exp();

    // start and abort together in IDLE: stays IDLE
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("t6_idle_abort_state", 32'(bus.state_dbg), 32'd0);
    repeat (8) tick();
    chk("t6_idle_abort_en",    32'(bus.rom_en), 32'd0);
    chk("t6_no_done",          32'(done_seen), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
